// File: rtl/u_ins_fetch_pkg.sv
// Shared processor definitions for the instruction-fetch stage: fetch FSM
// states, reset vector, NOP encoding and the IF/ID register payload.
package u_ins_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_INS              = 32'h0000_0000;
    localparam logic [31:0] PC_STEP              = 32'd4;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_EMPTY = '{ins: NOP_INS, pc_plus4: '0, valid: 1'b0};

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/u_ins_fetch_if_id_reg.sv
// IF/ID pipeline register: flush squashes to an empty NOP slot, stall holds,
// otherwise the fetched word and its PC+4 are captured as valid.
module u_if_id_reg
    import u_ins_fetch_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_ins,
    input  logic [31:0] i_pc_plus4,
    output logic [31:0] o_ins,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid,
    output logic        o_accept
);

    if_id_t if_id_q;
    if_id_t if_id_d;

    always_comb begin
        if_id_d  = if_id_q;
        o_accept = 1'b0;
        if (i_flush) begin
            if_id_d = IF_ID_EMPTY;
        end else if (!i_stall) begin
            if_id_d.ins      = i_ins;
            if_id_d.pc_plus4 = i_pc_plus4;
            if_id_d.valid    = 1'b1;
            o_accept         = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            if_id_q <= IF_ID_EMPTY;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign o_ins      = if_id_q.ins;
    assign o_pc_plus4 = if_id_q.pc_plus4;
    assign o_valid    = if_id_q.valid;

endmodule

// File: rtl/u_ins_fetch.sv
// Instruction fetch stage: IDLE/LOAD/RUN sequencing, PC redirect/stall logic,
// instruction-memory address mux and accepted-instruction counter.
module u_ins_fetch
    import u_ins_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        i_sys_clock,
    input  logic        i_sys_reset,
    input  logic        i_u_ins_fetch_start,
    input  logic        i_u_ins_fetch_load_en,
    input  logic [31:0] i_u_ins_fetch_load_addr,
    input  logic        i_u_ins_fetch_stall,
    input  logic        i_u_ins_fetch_flush,
    input  logic        i_u_ins_fetch_branch_taken,
    input  logic [31:0] i_u_ins_fetch_branch_target,
    input  logic        i_u_ins_fetch_jump,
    input  logic [31:0] i_u_ins_fetch_jump_target,
    input  logic [31:0] i_u_ins_fetch_imem_ins,
    output logic [31:0] o_u_ins_fetch_imem_addr,
    output logic [31:0] o_u_ins_fetch_pc,
    output logic [31:0] o_u_ins_fetch_if_id_ins,
    output logic [31:0] o_u_ins_fetch_if_id_pc_plus4,
    output logic        o_u_ins_fetch_if_id_valid,
    output logic [31:0] o_u_ins_fetch_ins_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ins_count_q, ins_count_d;
    logic [31:0]  pc_plus4;
    logic         if_id_stall;
    logic         if_id_flush;
    logic         if_id_accept;

    assign pc_plus4 = pc_q + PC_STEP;

    // Outside RUN (and on the RUN->LOAD edge) the IF/ID slot is forced empty
    // by driving the sub-module's flush; stall/flush from the pipeline only
    // matter while actually fetching.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        if_id_flush = 1'b1;
        if_id_stall = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_u_ins_fetch_load_en) begin
                    state_d = ST_LOAD;
                end else if (i_u_ins_fetch_start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_VECTOR;
                end
            end
            ST_LOAD: begin
                if (!i_u_ins_fetch_load_en) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_VECTOR;
                end
            end
            ST_RUN: begin
                if (i_u_ins_fetch_load_en) begin
                    state_d = ST_LOAD;
                    pc_d    = RESET_VECTOR;
                end else begin
                    if_id_flush = i_u_ins_fetch_flush;
                    if_id_stall = i_u_ins_fetch_stall;
                    if (i_u_ins_fetch_jump) begin
                        pc_d = word_align(i_u_ins_fetch_jump_target);
                    end else if (i_u_ins_fetch_branch_taken) begin
                        pc_d = word_align(i_u_ins_fetch_branch_target);
                    end else if (!i_u_ins_fetch_stall) begin
                        pc_d = pc_plus4;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = RESET_VECTOR;
            end
        endcase
    end

    always_comb begin
        ins_count_d = ins_count_q;
        if (if_id_accept) begin
            ins_count_d = ins_count_q + 32'd1;
        end
    end

    always_ff @(posedge i_sys_clock) begin
        if (i_sys_reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_VECTOR;
            ins_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ins_count_q <= ins_count_d;
        end
    end

    u_if_id_reg u_if_id (
        .i_clk      (i_sys_clock),
        .i_rst      (i_sys_reset),
        .i_stall    (if_id_stall),
        .i_flush    (if_id_flush),
        .i_ins      (i_u_ins_fetch_imem_ins),
        .i_pc_plus4 (pc_plus4),
        .o_ins      (o_u_ins_fetch_if_id_ins),
        .o_pc_plus4 (o_u_ins_fetch_if_id_pc_plus4),
        .o_valid    (o_u_ins_fetch_if_id_valid),
        .o_accept   (if_id_accept)
    );

    assign o_u_ins_fetch_imem_addr = (state_q == ST_LOAD) ? i_u_ins_fetch_load_addr : pc_q;
    assign o_u_ins_fetch_pc        = pc_q;
    assign o_u_ins_fetch_ins_count = ins_count_q;

endmodule

// File: tb/tb_u_ins_fetch.sv
// Bench for u_ins_fetch: directed scenarios plus randomized traffic, all
// checked against a cycle-level behavioural model of the fetch stage.
module tb_u_ins_fetch;

    localparam logic [31:0] RV = 32'h0040_0000;
    localparam int MODE_IDLE = 0;
    localparam int MODE_LOAD = 1;
    localparam int MODE_RUN  = 2;

    logic        clk = 1'b0;
    logic        rst, start, load_en, stall, flush, br, jmp;
    logic [31:0] load_addr, bt, jt, imem_ins;
    logic [31:0] imem_addr, pc, ifid_ins, ifid_pp4, ins_count;
    logic        ifid_valid;

    logic [31:0] mem [256];

    int          m_mode;
    logic [31:0] m_pc, m_ins, m_pp4, m_cnt;
    logic        m_valid;

    int n_checks = 0;
    int n_fail   = 0;

    assign imem_ins = mem[imem_addr[9:2]];

    always #5 clk = ~clk;

    u_ins_fetch #(.RESET_VECTOR(RV)) dut (
        .i_sys_clock                 (clk),
        .i_sys_reset                 (rst),
        .i_u_ins_fetch_start         (start),
        .i_u_ins_fetch_load_en       (load_en),
        .i_u_ins_fetch_load_addr     (load_addr),
        .i_u_ins_fetch_stall         (stall),
        .i_u_ins_fetch_flush         (flush),
        .i_u_ins_fetch_branch_taken  (br),
        .i_u_ins_fetch_branch_target (bt),
        .i_u_ins_fetch_jump          (jmp),
        .i_u_ins_fetch_jump_target   (jt),
        .i_u_ins_fetch_imem_ins      (imem_ins),
        .o_u_ins_fetch_imem_addr     (imem_addr),
        .o_u_ins_fetch_pc            (pc),
        .o_u_ins_fetch_if_id_ins     (ifid_ins),
        .o_u_ins_fetch_if_id_pc_plus4(ifid_pp4),
        .o_u_ins_fetch_if_id_valid   (ifid_valid),
        .o_u_ins_fetch_ins_count     (ins_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = MODE_IDLE;
        m_pc    = RV;
        m_ins   = 32'h0;
        m_pp4   = 32'h0;
        m_valid = 1'b0;
        m_cnt   = 32'h0;
    endtask

    task automatic model_clear_ifid();
        m_ins   = 32'h0;
        m_pp4   = 32'h0;
        m_valid = 1'b0;
    endtask

    // One clock edge of the fetch stage, expressed directly from its rules.
    task automatic model_edge();
        logic [31:0] fetched;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_mode == MODE_IDLE) begin
            model_clear_ifid();
            if (load_en) m_mode = MODE_LOAD;
            else if (start) begin m_mode = MODE_RUN; m_pc = RV; end
        end else if (m_mode == MODE_LOAD) begin
            model_clear_ifid();
            if (!load_en) begin m_mode = MODE_RUN; m_pc = RV; end
        end else if (load_en) begin
            model_clear_ifid();
            m_mode = MODE_LOAD;
            m_pc   = RV;
        end else begin
            fetched = mem[m_pc[9:2]];
            if (flush) model_clear_ifid();
            else if (!stall) begin
                m_ins   = fetched;
                m_pp4   = m_pc + 4;
                m_valid = 1'b1;
                m_cnt   = m_cnt + 1;
            end
            if (jmp)        m_pc = jt & 32'hFFFF_FFFC;
            else if (br)    m_pc = bt & 32'hFFFF_FFFC;
            else if (!stall) m_pc = m_pc + 4;
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1;
        check_eq("imem_addr", imem_addr, (m_mode == MODE_LOAD) ? load_addr : m_pc);
        model_edge();
        @(posedge clk);
        #1;
        check_eq("pc", pc, m_pc);
        check_eq("ifid_ins", ifid_ins, m_ins);
        check_eq("ifid_pc_plus4", ifid_pp4, m_pp4);
        check_eq("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
        check_eq("ins_count", ins_count, m_cnt);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        rst = 0; start = 0; load_en = 0; load_addr = RV; stall = 0; flush = 0;
        br = 0; bt = 32'h0; jmp = 0; jt = 32'h0;
    endtask

    task automatic write_load(input logic [31:0] a, output logic [31:0] w);
        w = $urandom;
        load_en = 1;
        load_addr = a;
        mem[a[9:2]] = w;
    endtask

    task automatic rand_cycle();
        rst   = ($urandom_range(0, 99) < 2);
        start = ($urandom_range(0, 3) == 0);
        if (m_mode == MODE_LOAD) load_en = ($urandom_range(0, 4) != 0);
        else                     load_en = ($urandom_range(0, 19) == 0);
        load_addr = RV + ($urandom_range(0, 63) << 2);
        if (load_en) mem[load_addr[9:2]] = $urandom;
        stall = ($urandom_range(0, 3) == 0);
        flush = ($urandom_range(0, 7) == 0);
        br    = ($urandom_range(0, 7) == 0);
        bt    = RV + $urandom_range(0, 1023);
        jmp   = ($urandom_range(0, 15) == 0);
        jt    = ($urandom_range(0, 3) == 0) ? $urandom : (RV + $urandom_range(0, 1023));
        step();
    endtask

    logic [31:0] w0, wtmp;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        drive_idle();
        rst = 1;
        @(negedge clk);
        model_reset();
        step();

        // Basic sequential fetch after start.
        drive_idle(); start = 1; step();
        check_eq("r32_state_run_addr", imem_addr, 32'h0040_0000);
        drive_idle();
        for (int i = 0; i < 3; i++) step();
        check_eq("r32_count3", ins_count, 32'd3);

        // Stall two cycles, then resume.
        stall = 1; step(); step();
        check_eq("r34_pc_held", pc, 32'h0040_000C);
        check_eq("r34_count_held", ins_count, 32'd3);
        stall = 0; step();
        check_eq("r34_resume_pc", pc, 32'h0040_0010);

        // Stall + branch + flush in the same cycle; unaligned target.
        stall = 1; flush = 1; br = 1; bt = 32'h0040_0103; step();
        check_eq("r35_pc", pc, 32'h0040_0100);
        check_eq("r35_valid", {31'b0, ifid_valid}, 32'd0);
        drive_idle();

        // Jump beats branch.
        jmp = 1; jt = 32'h0040_0200; br = 1; bt = 32'h0040_0300; step();
        check_eq("r36_pc", pc, 32'h0040_0200);
        drive_idle();

        // PC wrap.
        jmp = 1; jt = 32'hFFFF_FFFC; step();
        drive_idle(); step();
        check_eq("r37_wrap_pc", pc, 32'h0000_0000);

        // Program load from RUN, then exit and fetch the first loaded word.
        write_load(32'h0040_0000, w0); step();
        write_load(32'h0040_0004, wtmp); step();
        write_load(32'h0040_0008, wtmp); step();
        write_load(32'h0040_000C, wtmp); step();
        check_eq("r33_pc_held", pc, 32'h0040_0000);
        drive_idle(); step();
        step();
        check_eq("r33_first_word", ifid_ins, w0);

        // Reset mid-RUN at PC 0x40 with 16 accepted words.
        drive_idle(); rst = 1; step();
        drive_idle(); start = 1; step();
        drive_idle();
        for (int i = 0; i < 16; i++) step();
        check_eq("r37_pc_before", pc, 32'h0040_0040);
        check_eq("r37_cnt_before", ins_count, 32'd16);
        rst = 1; step();
        check_eq("r37_rst_pc", pc, 32'h0040_0000);
        check_eq("r37_rst_cnt", ins_count, 32'd0);
        drive_idle();

        for (int i = 0; i < 3000; i++) rand_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/u_ins_fetch.md
U_INS_FETCH -- requirements
Module: u_ins_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0040_0000, PC value after reset, load exit or start.
REQ-002 SHALL have port i_sys_clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_sys_reset  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_u_ins_fetch_start  in  1  leave IDLE and begin fetching.
REQ-005 SHALL have port i_u_ins_fetch_load_en  in  1  program-load mode request; instruction memory is being written.
REQ-006 SHALL have port i_u_ins_fetch_load_addr  in  32  loader byte address, forwarded to instruction memory in LOAD.
REQ-007 SHALL have port i_u_ins_fetch_stall  in  1  hold PC and IF/ID register.
REQ-008 SHALL have port i_u_ins_fetch_flush  in  1  squash IF/ID contents to NOP.
REQ-009 SHALL have ports i_u_ins_fetch_branch_taken / i_u_ins_fetch_branch_target  in  1 / 32  branch redirect.
REQ-010 SHALL have ports i_u_ins_fetch_jump / i_u_ins_fetch_jump_target  in  1 / 32  jump redirect.
REQ-011 SHALL have port i_u_ins_fetch_imem_ins  in  32  instruction word from instruction memory.
REQ-012 SHALL have port o_u_ins_fetch_imem_addr  out  32  byte address to instruction memory.
REQ-013 SHALL have port o_u_ins_fetch_pc  out  32  current PC.
REQ-014 SHALL have ports o_u_ins_fetch_if_id_ins / o_u_ins_fetch_if_id_pc_plus4 / o_u_ins_fetch_if_id_valid  out  32 / 32 / 1  IF/ID register.
REQ-015 SHALL have port o_u_ins_fetch_ins_count  out  32  count of instructions accepted into IF/ID.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, RUN.
REQ-017 IDLE: load_en -> LOAD; else start -> RUN; otherwise stay IDLE.
REQ-018 LOAD: load_en=0 -> RUN; PC set to RESET_VECTOR on that exit edge.
REQ-019 RUN: load_en=1 -> LOAD; PC set to RESET_VECTOR and IF/ID cleared on that edge.
REQ-020 o_u_ins_fetch_imem_addr SHALL equal load_addr in LOAD and PC in IDLE/RUN (combinational mux).
REQ-021 In RUN, next-PC priority: jump -> jump_target; else branch_taken -> branch_target; else stall -> hold; else PC+4.
REQ-022 Redirect SHALL take effect even when stall=1.
REQ-023 Redirect targets SHALL have bits [1:0] forced to 0; PC+4 wraps modulo 2^32.
REQ-024 IF/ID update in RUN, priority: flush -> ins=0, valid=0, pc_plus4=0; else stall -> hold; else ins=imem_ins, pc_plus4=PC+4, valid=1.
REQ-025 Fetch latency SHALL be one cycle: word at PC appears on IF/ID outputs the edge after PC is presented.
REQ-026 In IDLE and LOAD, PC SHALL hold and IF/ID SHALL be ins=0, valid=0.
REQ-027 ins_count SHALL increment by 1 on each edge where REQ-024 loads a valid word; wraps at 2^32; cleared only by reset.

Reset
REQ-028 i_sys_reset SHALL take priority over all inputs, including mid-RUN and mid-LOAD.
REQ-029 Reset values: state=IDLE, PC=RESET_VECTOR, if_id_ins=0, if_id_pc_plus4=0, if_id_valid=0, ins_count=0.

Structure
REQ-030 State enum, RESET_VECTOR default and NOP encoding (32'h0) SHALL live in the shared processor package.
REQ-031 The IF/ID register SHALL be a sub-module u_if_id_reg (stall, flush, valid); PC logic and FSM stay in u_ins_fetch.

Verification
REQ-032 Reset, start, no hazards -> imem_addr 0x00400000, 0x00400004, 0x00400008 on successive cycles; valid=1 from cycle 2; ins_count=3 after 3 accepted words.
REQ-033 load_en=1 for 4 cycles with load_addr 0x00400000..0x0040000C -> imem_addr tracks load_addr, valid=0, PC=0x00400000 held; load_en falls -> RUN, first IF/ID word is the word written at 0x00400000.
REQ-034 In RUN, stall=1 for 2 cycles -> PC and IF/ID held, ins_count unchanged; release -> resumes at PC+4.
REQ-035 Same cycle: stall=1, branch_taken=1, target 0x00400103, flush=1 -> next PC=0x00400100, IF/ID valid=0, ins=0.
REQ-036 Same cycle: jump=1 (target 0x00400200), branch_taken=1 (target 0x00400300) -> next PC=0x00400200.
REQ-037 i_sys_reset asserted mid-RUN with PC=0x00400040, ins_count=16 -> next edge: IDLE, PC=0x00400000, ins_count=0, valid=0; PC at 0xFFFFFFFC in RUN -> next PC=0x00000000.
